// File: rtl/nios_system_sysid_ext_if.sv
// Avalon-MM slave bus bundle for the system-ID peripheral: fixed read latency, no waitrequest.
interface nios_system_sysid_ext_if;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        readdatavalid;

  modport slave (
    input  address, read, write, writedata,
    output readdata, readdatavalid
  );

  modport master (
    output address, read, write, writedata,
    input  readdata, readdatavalid
  );
endinterface

// File: rtl/nios_system_sysid_ext.sv
// System-ID slave: ID/timestamp words, prescaled uptime counter with coherent 64-bit
// snapshot read, scratch register and control/status register.
module nios_system_sysid_ext #(
  parameter logic [31:0] ID_VALUE  = 32'h50413D65,
  parameter logic [31:0] TIMESTAMP = 32'd0,
  parameter int          CNT_W     = 64,
  parameter int          PRESCALE  = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  nios_system_sysid_ext_if.slave bus
);

  localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

  logic [CNT_W-1:0]  counter;
  logic [CNT_W-33:0] snapshot;
  logic [15:0]       prescaler;
  logic [31:0]       scratch;
  logic              en;
  logic              wrap;

  logic              tick;
  logic              clr;
  logic              wr_scratch;
  logic              wr_ctrl;
  logic              rd_lo;
  logic [31:0]       read_mux;

  always_comb begin
    wr_scratch = bus.write && (bus.address == 3'd4);
    wr_ctrl    = bus.write && (bus.address == 3'd5);
    clr        = wr_ctrl && bus.writedata[1];
    rd_lo      = bus.read && (bus.address == 3'd2);
    tick       = en && (prescaler == PS_LAST);
  end

  // Read data comes from the pre-edge register values, so a same-cycle write is not visible.
  always_comb begin
    read_mux = 32'd0;
    case (bus.address)
      3'd0:    read_mux = ID_VALUE;
      3'd1:    read_mux = TIMESTAMP;
      3'd2:    read_mux = counter[31:0];
      3'd3:    read_mux = 32'(snapshot);
      3'd4:    read_mux = scratch;
      3'd5:    read_mux = {29'd0, wrap, 1'b0, en};
      default: read_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prescaler <= 16'd0;
      counter   <= '0;
    end else if (clr) begin
      prescaler <= 16'd0;
      counter   <= '0;
    end else if (en) begin
      prescaler <= tick ? 16'd0 : prescaler + 16'd1;
      if (tick) begin
        counter <= counter + CNT_W'(1);
      end
    end
  end

  // A wrap that happens on the same edge as a clear-request keeps WRAP set.
  always_ff @(posedge clock) begin
    if (reset) begin
      en      <= 1'b1;
      wrap    <= 1'b0;
      scratch <= 32'd0;
    end else begin
      if (wr_ctrl) begin
        en <= bus.writedata[0];
      end
      if (tick && (&counter) && !clr) begin
        wrap <= 1'b1;
      end else if (wr_ctrl && bus.writedata[2]) begin
        wrap <= 1'b0;
      end
      if (wr_scratch) begin
        scratch <= bus.writedata;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      snapshot          <= '0;
      bus.readdata      <= 32'd0;
      bus.readdatavalid <= 1'b0;
    end else begin
      bus.readdatavalid <= bus.read;
      if (bus.read) begin
        bus.readdata <= read_mux;
      end
      if (rd_lo) begin
        snapshot <= counter[CNT_W-1:32];
      end
    end
  end

endmodule
